// File: rtl/memc_deskew_if.sv
// memc_deskew_if
//   Bundles the result-stream, control and read-back signals of memc_deskew.
//   master : driver side (systolic array drain + host), drives en/Cin/clr/RdEn/Crow
//   slave  : memc_deskew itself, drives Cout/rd_valid/done/ovf
//   Signals:
//     en       beat qualifier for lane 0 (C[r][0] valid on Cin[0])
//     Cin      DIM signed lanes, lane j valid j cycles after its row's en beat
//     clr      synchronous restart of capture (buffer contents kept)
//     RdEn     read request, Crow selects the row
//     Cout     registered read data, rd_valid marks a fresh read
//     done     all DIM rows captured
//     ovf      sticky: an en beat was rejected
interface memc_deskew_if #(
  parameter int BITS_C = 24,
  parameter int DIM    = 8
);
  localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;

  logic                     en;
  logic signed [BITS_C-1:0] Cin [DIM];
  logic                     clr;
  logic                     RdEn;
  logic [RW-1:0]            Crow;
  logic signed [BITS_C-1:0] Cout [DIM];
  logic                     rd_valid;
  logic                     done;
  logic                     ovf;

  modport master (
    output en, Cin, clr, RdEn, Crow,
    input  Cout, rd_valid, done, ovf
  );

  modport slave (
    input  en, Cin, clr, RdEn, Crow,
    output Cout, rd_valid, done, ovf
  );
endinterface

// File: rtl/memc_deskew.sv
// memc_deskew
//   Re-aligns the diagonally skewed result stream leaving the systolic array
//   (lane j lags lane 0 by j cycles), writes each aligned row into a DIM x DIM
//   row buffer and raises done once the whole matrix is captured. The host
//   reads rows back by index with one cycle of latency.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset (clears everything, buffer included)
//     bus  memc_deskew_if.slave (en, Cin, clr, RdEn, Crow / Cout, rd_valid, done, ovf)
//   Requires DIM >= 2.
module memc_deskew #(
  parameter int BITS_C = 24,
  parameter int DIM    = 8
) (
  input  logic         clk,
  input  logic         rst,
  memc_deskew_if.slave bus
);

  localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int CW = $clog2(DIM + 1);
  localparam int PD = DIM - 1;  // valid-pipe depth == lane-0 deskew depth

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t                   state_r;
  state_t                   state_s;
  logic [CW-1:0]            acc_cnt_r;
  logic [RW-1:0]            wr_row_r;
  logic [PD-1:0]            vld_r;
  logic signed [BITS_C-1:0] aligned_s [DIM];
  logic signed [BITS_C-1:0] buf_r [DIM][DIM];
  logic signed [BITS_C-1:0] cout_r [DIM];
  logic                     rd_valid_r;
  logic                     done_r;
  logic                     ovf_r;
  logic                     accept_s;
  logic                     reject_s;
  logic                     wr_s;
  logic                     last_s;

  // Beat admission: clr swallows a coincident beat silently; otherwise a beat
  // is rejected once DIM rows are already accepted or the matrix is full.
  always_comb begin
    accept_s = 1'b0;
    reject_s = 1'b0;
    if (bus.en && !bus.clr) begin
      if ((acc_cnt_r < CW'(DIM)) && (state_r != FULL)) begin
        accept_s = 1'b1;
      end else begin
        reject_s = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
      reject_s = 1'b0;
    end
  end

  // A strobe coinciding with clr belongs to a discarded beat, so it is not written.
  assign wr_s   = vld_r[PD-1] && !bus.clr;
  assign last_s = wr_s && (wr_row_r == RW'(DIM - 1));

  // Next-state logic of the capture FSM.
  always_comb begin
    state_s = state_r;
    if (bus.clr) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    if (accept_s) state_s = FILL; else state_s = IDLE;
        FILL:    if (last_s)   state_s = FULL; else state_s = FILL;
        FULL:    state_s = FULL;
        default: state_s = IDLE;
      endcase
    end
  end

  // Capture control registers: FSM state, counters, valid pipe and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      acc_cnt_r <= '0;
      wr_row_r  <= '0;
      vld_r     <= '0;
      done_r    <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= (state_s == FULL);
      if (bus.clr) begin
        acc_cnt_r <= '0;
        wr_row_r  <= '0;
        vld_r     <= '0;
        ovf_r     <= 1'b0;
      end else begin
        vld_r <= (vld_r << 1) | PD'(accept_s);
        if (accept_s) acc_cnt_r <= acc_cnt_r + CW'(1);
        if (wr_s)     wr_row_r  <= wr_row_r + RW'(1);
        if (reject_s) ovf_r     <= 1'b1;
      end
    end
  end

  // Per-lane deskew: lane j gets DIM-1-j stages so every lane of a row
  // arrives together with the write strobe.
  for (genvar j = 0; j < DIM; j++) begin : g_lane
    assign bus.Cout[j] = cout_r[j];
    if (j == DIM - 1) begin : g_direct
      assign aligned_s[j] = bus.Cin[j];
    end else begin : g_dly
      localparam int NS = DIM - 1 - j;
      logic signed [BITS_C-1:0] stg_r [NS];
      // Free-running shift chain for this lane.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < NS; k++) stg_r[k] <= '0;
        end else begin
          stg_r[0] <= bus.Cin[j];
          for (int k = 1; k < NS; k++) stg_r[k] <= stg_r[k-1];
        end
      end
      assign aligned_s[j] = stg_r[NS-1];
    end
  end

  // Row buffer write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DIM; r++) begin
        for (int j = 0; j < DIM; j++) buf_r[r][j] <= '0;
      end
    end else if (wr_s) begin
      for (int j = 0; j < DIM; j++) buf_r[wr_row_r][j] <= aligned_s[j];
    end
  end

  // Registered read port; a same-edge write is not visible (pre-write data).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
      for (int j = 0; j < DIM; j++) cout_r[j] <= '0;
    end else begin
      rd_valid_r <= bus.RdEn;
      if (bus.RdEn) begin
        for (int j = 0; j < DIM; j++) cout_r[j] <= buf_r[bus.Crow][j];
      end
    end
  end

  assign bus.rd_valid = rd_valid_r;
  assign bus.done     = done_r;
  assign bus.ovf      = ovf_r;

endmodule

// File: tb/tb_memc_deskew.sv
// tb_memc_deskew
//   Directed bench for memc_deskew (DIM=8, BITS_C=24). Each row r is launched
//   at a chosen cycle; lane j of that row is presented j cycles later.
module tb_memc_deskew;
  localparam int BITS_C = 24;
  localparam int DIM    = 8;
  localparam int NEVER  = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memc_deskew_if #(.BITS_C(BITS_C), .DIM(DIM)) bus ();

  memc_deskew #(.BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;
  int beat_c [DIM];
  int done_c;
  logic signed [BITS_C-1:0] rdat [DIM];
  logic rvld;
  int bad;

  // Expected element for each data pattern.
  function automatic logic signed [BITS_C-1:0] elem(input int mode, input int r, input int j);
    case (mode)
      0:       return BITS_C'(16 * r + j);
      1:       return BITS_C'(-(r + j));
      2:       return 24'sh7FFFFF;
      default: return BITS_C'(100 * r + j + 1000);
    endcase
  endfunction

  task automatic set_beats(input int n, input int gap_at, input int gap_len);
    for (int r = 0; r < DIM; r++)
      beat_c[r] = (r >= n) ? NEVER : r + ((r >= gap_at) ? gap_len : 0);
  endtask

  task automatic drive_idle();
    bus.en = 1'b0; bus.clr = 1'b0; bus.RdEn = 1'b0; bus.Crow = '0;
    for (int j = 0; j < DIM; j++) bus.Cin[j] = '0;
  endtask

  // Inputs for cycle c (applied before edge c of the sequence).
  task automatic drive_cycle(input int c, input int mode);
    bus.en = 1'b0;
    for (int j = 0; j < DIM; j++) begin
      bus.Cin[j] = '0;
      for (int r = 0; r < DIM; r++)
        if (beat_c[r] + j == c) bus.Cin[j] = elem(mode, r, j);
    end
    for (int r = 0; r < DIM; r++) if (beat_c[r] == c) bus.en = 1'b1;
  endtask

  // Runs a full capture; done_c = first edge index after which done is seen.
  task automatic run_capture(input int mode);
    done_c = -1;
    for (int c = 0; c < beat_c[DIM-1] + DIM + 2; c++) begin
      drive_cycle(c, mode);
      @(posedge clk); #1;
      if (bus.done && done_c < 0) done_c = c;
    end
    drive_idle();
  endtask

  task automatic do_clr();
    drive_idle();
    bus.clr = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
  endtask

  task automatic read_row(input int r);
    bus.RdEn = 1'b1; bus.Crow = 3'(r);
    @(posedge clk); #1;
    bus.RdEn = 1'b0;
    rvld = bus.rd_valid;
    for (int j = 0; j < DIM; j++) rdat[j] = bus.Cout[j];
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bad = 0;
    for (int j = 0; j < DIM; j++) if (bus.Cout[j] !== '0) bad = 1;
    vectors++;
    if (bad != 0 || bus.rd_valid !== 1'b0 || bus.done !== 1'b0 || bus.ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state cout0=%0d rd_valid=%b done=%b ovf=%b required 0/0/0/0",
               bus.Cout[0], bus.rd_valid, bus.done, bus.ovf);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_aligned();
    set_beats(DIM, DIM, 0);
    run_capture(0);
    vectors++;
    if (done_c !== 14 || bus.ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL aligned_done done_edge=%0d ovf=%b required 14/0", done_c, bus.ovf);
    end
    for (int r = 0; r < DIM; r++) begin
      read_row(r);
      bad = 0;
      for (int j = 0; j < DIM; j++)
        if (rdat[j] !== elem(0, r, j) && bad == 0) begin
          bad = 1;
          $display("FAIL aligned_row r=%0d lane=%0d got=%0d required=%0d", r, j, rdat[j], elem(0, r, j));
        end
      if (rvld !== 1'b1) begin bad = 1; $display("FAIL aligned_rd_valid r=%0d got=%b required=1", r, rvld); end
      vectors++;
      if (bad != 0) miscompares++;
    end
  endtask

  task automatic test_overflow();
    set_beats(3, DIM, 0);
    for (int c = 0; c < 12; c++) begin
      drive_cycle(c, 2);
      @(posedge clk); #1;
    end
    drive_idle();
    vectors++;
    if (bus.ovf !== 1'b1 || bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_flags ovf=%b done=%b required 1/1", bus.ovf, bus.done);
    end
    for (int r = 0; r < DIM; r++) begin
      read_row(r);
      bad = 0;
      for (int j = 0; j < DIM; j++) if (rdat[j] !== elem(0, r, j)) bad = 1;
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL overflow_buffer_kept r=%0d lane0 got=%0d required=%0d", r, rdat[0], elem(0, r, 0));
      end
    end
    do_clr();
    // clr together with en: beat dropped, ovf stays clear
    bus.en = 1'b1; bus.clr = 1'b1;
    @(posedge clk); #1;
    drive_idle();
    vectors++;
    if (bus.ovf !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_clr ovf=%b done=%b required 0/0", bus.ovf, bus.done);
    end
    set_beats(DIM, DIM, 0);
    run_capture(1);
    vectors++;
    if (done_c !== 14 || bus.ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL recapture_done done_edge=%0d ovf=%b required 14/0", done_c, bus.ovf);
    end
    for (int r = 0; r < DIM; r++) begin
      read_row(r);
      bad = 0;
      for (int j = 0; j < DIM; j++) if (rdat[j] !== elem(1, r, j)) bad = 1;
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL recapture_negative r=%0d lane7 got=%0d required=%0d", r, rdat[DIM-1], elem(1, r, DIM-1));
      end
    end
  endtask

  task automatic test_gapped();
    do_clr();
    set_beats(DIM, 4, 3);
    run_capture(0);
    vectors++;
    if (done_c !== 17 || bus.ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL gapped_done done_edge=%0d ovf=%b required 17/0", done_c, bus.ovf);
    end
    for (int r = 0; r < DIM; r++) begin
      read_row(r);
      bad = 0;
      for (int j = 0; j < DIM; j++) if (rdat[j] !== elem(0, r, j)) bad = 1;
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL gapped_row r=%0d lane3 got=%0d required=%0d", r, rdat[3], elem(0, r, 3));
      end
    end
  endtask

  task automatic test_clr_mid_fill();
    do_clr();
    set_beats(5, DIM, 0);
    for (int c = 0; c < 22; c++) begin
      drive_cycle(c, 3);
      bus.clr = (c == 7);  // 3 cycles after the 5th beat (edge 4)
      @(posedge clk); #1;
    end
    drive_idle();
    vectors++;
    if (bus.done !== 1'b0 || bus.ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_mid_flags done=%b ovf=%b required 0/0", bus.done, bus.ovf);
    end
    for (int r = 1; r < 5; r++) begin
      read_row(r);
      bad = 0;
      for (int j = 0; j < DIM; j++) if (rdat[j] !== elem(0, r, j)) bad = 1;
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL clr_mid_discard r=%0d lane0 got=%0d required=%0d", r, rdat[0], elem(0, r, 0));
      end
    end
    set_beats(DIM, DIM, 0);
    run_capture(1);
    vectors++;
    if (done_c !== 14) begin
      miscompares++;
      $display("FAIL clr_mid_refill_done done_edge=%0d required=14", done_c);
    end
    for (int r = 0; r < DIM; r++) begin
      read_row(r);
      bad = 0;
      for (int j = 0; j < DIM; j++) if (rdat[j] !== elem(1, r, j)) bad = 1;
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL clr_mid_refill_row r=%0d lane0 got=%0d required=%0d", r, rdat[0], elem(1, r, 0));
      end
    end
  endtask

  task automatic test_collision();
    do_clr();
    set_beats(DIM, DIM, 0);
    for (int c = 0; c < 13; c++) begin
      drive_cycle(c, 0);
      bus.RdEn = (c == 9 || c == 10);  // row 2 is written at edge 9
      bus.Crow = 3'd2;
      @(posedge clk); #1;
      if (c >= 9 && c <= 11) begin
        bad = 0;
        for (int j = 0; j < DIM; j++)
          if (bus.Cout[j] !== elem((c == 9) ? 1 : 0, 2, j)) bad = 1;
        if (bus.rd_valid !== ((c == 11) ? 1'b0 : 1'b1)) bad = 1;
        vectors++;
        if (bad != 0) begin
          miscompares++;
          $display("FAIL collision edge=%0d cout0=%0d rd_valid=%b required=%0d/%b", c, bus.Cout[0],
                   bus.rd_valid, elem((c == 9) ? 1 : 0, 2, 0), (c == 11) ? 1'b0 : 1'b1);
        end
      end
    end
    drive_idle();
  endtask

  task automatic test_async_reset();
    do_clr();
    set_beats(DIM, DIM, 0);
    for (int c = 0; c < 11; c++) begin
      drive_cycle(c, 3);
      bus.RdEn = (c == 10); bus.Crow = 3'd0;
      @(posedge clk); #1;
    end
    drive_idle();
    vectors++;
    if (bus.rd_valid !== 1'b1 || bus.Cout[0] !== elem(3, 0, 0)) begin
      miscompares++;
      $display("FAIL pre_reset_read cout0=%0d rd_valid=%b required=%0d/1", bus.Cout[0], bus.rd_valid, elem(3, 0, 0));
    end
    #2 rst = 1'b1;
    #1;
    bad = 0;
    for (int j = 0; j < DIM; j++) if (bus.Cout[j] !== '0) bad = 1;
    vectors++;
    if (bad != 0 || bus.rd_valid !== 1'b0 || bus.done !== 1'b0 || bus.ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_outputs cout0=%0d rd_valid=%b done=%b ovf=%b required 0/0/0/0",
               bus.Cout[0], bus.rd_valid, bus.done, bus.ovf);
    end
    @(posedge clk); #3;
    rst = 1'b0;
    for (int r = 0; r < DIM; r++) begin
      read_row(r);
      bad = 0;
      for (int j = 0; j < DIM; j++) if (rdat[j] !== '0) bad = 1;
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL async_reset_row r=%0d lane0 got=%0d required=0", r, rdat[0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_aligned();
    test_overflow();
    test_gapped();
    test_clr_mid_fill();
    test_collision();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
